// File: rtl/axi_rd_arb.sv
// axi_rd_arb: round-robin arbiter sharing one AXI read master port among
// NREQ requesters. Each AR burst is tagged with the requester index in the ID
// field, and returning R beats are steered back to that requester by ID.
// Build option: define ARB_STATS_EN to add per-requester grant counters
// (grant_cnt output).
module axi_rd_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDX_W   = 2,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_arvalid,
    input  logic [64*NREQ-1:0]   req_araddr,
    input  logic [8*NREQ-1:0]    req_arlen,
    output logic [NREQ-1:0]      req_arready,
    output logic [NREQ-1:0]      req_rvalid,
    output logic [511:0]         req_rdata,
    output logic [1:0]           req_rresp,
    output logic                 req_rlast,
    input  logic [NREQ-1:0]      req_rready,
    output logic [15:0]          arid_m,
    output logic [63:0]          araddr_m,
    output logic [7:0]           arlen_m,
    output logic [2:0]           arsize_m,
    output logic                 arvalid_m,
    input  logic                 arready_m,
    input  logic [15:0]          rid_m,
    input  logic [511:0]         rdata_m,
    input  logic [1:0]           rresp_m,
    input  logic                 rlast_m,
    input  logic                 rvalid_m,
    output logic                 rready_m,
    output logic                 err
`ifdef ARB_STATS_EN
    ,
    output logic [32*NREQ-1:0]   grant_cnt
`endif
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [63:0]        addr_q, addr_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         out_cnt_q, out_cnt_d;
    logic               err_q, err_d;

    // round-robin search results
    logic               hi_found, lo_found;
    logic [IDX_W-1:0]   hi_idx, lo_idx;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [63:0]        addr_sel;
    logic [7:0]         len_sel;

    // handshakes and R-side decode
    logic               ar_hs;
    logic               rlast_hs;
    logic [IDX_W-1:0]   r_idx;
    logic               r_id_ok;
    logic               r_sel_ready;

    assign ar_hs    = (state_q == S_ISSUE) && arready_m;
    assign rlast_hs = rvalid_m && rready_m && rlast_m;

    assign arid_m    = {{(16-IDX_W){1'b0}}, grant_q};
    assign araddr_m  = addr_q;
    assign arlen_m   = len_q;
    assign arsize_m  = 3'd6;
    assign arvalid_m = (state_q == S_ISSUE);
    assign err       = err_q;

    assign req_rdata = rdata_m;
    assign req_rresp = rresp_m;
    assign req_rlast = rlast_m;

    // Round-robin pick: the lowest requesting index at or above rr_ptr wins;
    // otherwise wrap around to the lowest requesting index overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req_arvalid[i]) begin
                if (!lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = IDX_W'(i);
                end
                if (!hi_found && (i >= 32'(rr_ptr_q))) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        pick_found = lo_found;
        pick_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Select the winning requester's address and length
    always_comb begin
        addr_sel = '0;
        len_sel  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                addr_sel = req_araddr[64*i +: 64];
                len_sel  = req_arlen[8*i +: 8];
            end
        end
    end

    // Per-requester AR accept pulse, only during the master-side handshake
    always_comb begin
        req_arready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            req_arready[i] = ar_hs && (grant_q == IDX_W'(i));
        end
    end

    // R-channel steering by ID; bad IDs are sunk so the memory never stalls
    always_comb begin
        r_idx       = rid_m[IDX_W-1:0];
        r_id_ok     = (rid_m[15:IDX_W] == '0) && (32'(r_idx) < NREQ);
        r_sel_ready = 1'b0;
        req_rvalid  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (r_idx == IDX_W'(i)) begin
                r_sel_ready   = req_rready[i];
                req_rvalid[i] = rvalid_m && r_id_ok;
            end
        end
        rready_m = r_id_ok ? r_sel_ready : 1'b1;
    end

    // Next-state: arbitration FSM, outstanding-burst count and sticky error
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        out_cnt_d = out_cnt_q;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (pick_found && (32'(out_cnt_q) < MAX_OUT)) begin
                    state_d = S_ISSUE;
                    grant_d = pick_idx;
                    addr_d  = addr_sel;
                    len_d   = len_sel;
                end
            end
            S_ISSUE: begin
                if (arready_m) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = (32'(grant_q) == NREQ - 1) ? '0 : grant_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A new burst and a completed burst in the same cycle cancel out
        if (ar_hs && !rlast_hs) begin
            out_cnt_d = out_cnt_q + 8'd1;
        end else if (!ar_hs && rlast_hs) begin
            if (out_cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q - 8'd1;
            end
        end

        if (rvalid_m && !r_id_ok) begin
            err_d = 1'b1;
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    // Latched AR payload; only meaningful while in ISSUE, so no reset
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        len_q  <= len_d;
    end

`ifdef ARB_STATS_EN
    logic [31:0] gcnt_q [NREQ];

    // Saturating per-requester count of accepted AR bursts
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (req_arready[i] && (gcnt_q[i] != '1)) begin
                    gcnt_q[i] <= gcnt_q[i] + 32'd1;
                end
            end
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt[32*i +: 32] = gcnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arb.sv
module tb_axi_rd_arb;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned MAX_OUT = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_arvalid;
  logic [64*NREQ-1:0]  req_araddr;
  logic [8*NREQ-1:0]   req_arlen;
  logic [NREQ-1:0]     req_arready;
  logic [NREQ-1:0]     req_rvalid;
  logic [511:0]        req_rdata;
  logic [1:0]          req_rresp;
  logic                req_rlast;
  logic [NREQ-1:0]     req_rready;
  logic [15:0]         arid_m;
  logic [63:0]         araddr_m;
  logic [7:0]          arlen_m;
  logic [2:0]          arsize_m;
  logic                arvalid_m;
  logic                arready_m;
  logic [15:0]         rid_m;
  logic [511:0]        rdata_m;
  logic [1:0]          rresp_m;
  logic                rlast_m;
  logic                rvalid_m;
  logic                rready_m;
  logic                err;

  int total = 0;
  int bad   = 0;

  logic [511:0] dexp;
  logic [1:0]   rexp;
  logic         lexp;
  logic [63:0]  aexp;
  logic [3:0]   gexp;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  axi_rd_arb #(
    .NREQ    (NREQ),
    .IDX_W   (IDX_W),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_arvalid (req_arvalid),
    .req_araddr  (req_araddr),
    .req_arlen   (req_arlen),
    .req_arready (req_arready),
    .req_rvalid  (req_rvalid),
    .req_rdata   (req_rdata),
    .req_rresp   (req_rresp),
    .req_rlast   (req_rlast),
    .req_rready  (req_rready),
    .arid_m      (arid_m),
    .araddr_m    (araddr_m),
    .arlen_m     (arlen_m),
    .arsize_m    (arsize_m),
    .arvalid_m   (arvalid_m),
    .arready_m   (arready_m),
    .rid_m       (rid_m),
    .rdata_m     (rdata_m),
    .rresp_m     (rresp_m),
    .rlast_m     (rlast_m),
    .rvalid_m    (rvalid_m),
    .rready_m    (rready_m),
    .err         (err)
  );

  always #5 clk = ~clk;

  initial begin
    rst         = 1'b0;
    req_arvalid = '0;
    req_araddr  = '0;
    req_arlen   = '0;
    req_rready  = '0;
    arready_m   = 1'b0;
    rid_m       = '0;
    rdata_m     = '0;
    rresp_m     = '0;
    rlast_m     = 1'b0;
    rvalid_m    = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arvalid", arvalid_m, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_arready", req_arready, 4'b0000);
    chk("rst_rvalid", req_rvalid, 4'b0000);
    chk("rst_arsize", arsize_m, 3'd6);
    chk("rst_outcnt", dut.out_cnt_q, 8'd0);
    chk("rst_rrptr", dut.rr_ptr_q, 3'd0);

    @(posedge clk); #1;
    rst = 1'b1;
    req_araddr[64*2 +: 64] = 64'h1000;
    req_arlen[8*2 +: 8]    = 8'd3;
    req_arvalid            = 4'b0100;
    @(negedge clk);
    chk("t1_arvalid_pre", arvalid_m, 1'b0);
    @(posedge clk); #1;
    arready_m = 1'b1;
    @(negedge clk);
    chk("t1_arvalid", arvalid_m, 1'b1);
    chk("t1_arid", arid_m, 16'd2);
    chk("t1_araddr", araddr_m, 64'h1000);
    chk("t1_arlen", arlen_m, 8'd3);
    chk("t1_arready", req_arready, 4'b0100);
    @(posedge clk); #1;
    arready_m   = 1'b0;
    req_arvalid = '0;
    @(negedge clk);
    chk("t1_arvalid_post", arvalid_m, 1'b0);
    chk("t1_arready_post", req_arready, 4'b0000);
    chk("t1_outcnt1", dut.out_cnt_q, 8'd1);
    req_rready = 4'b0100;
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      dexp     = {16{32'hD000_0000 | 32'(b)}};
      rexp     = (b == 1) ? 2'b10 : 2'b00;
      lexp     = (b == 3);
      rvalid_m = 1'b1;
      rid_m    = 16'd2;
      rdata_m  = dexp;
      rresp_m  = rexp;
      rlast_m  = lexp;
      @(negedge clk);
      chk("t1_rvalid", req_rvalid, 4'b0100);
      chk("t1_rready_m", rready_m, 1'b1);
      chk("t1_rdata", req_rdata, dexp);
      chk("t1_rresp", req_rresp, rexp);
      chk("t1_rlast", req_rlast, lexp);
    end
    @(posedge clk); #1;
    rvalid_m   = 1'b0;
    rlast_m    = 1'b0;
    rresp_m    = '0;
    req_rready = '0;
    @(negedge clk);
    chk("t1_outcnt0", dut.out_cnt_q, 8'd0);
    chk("t1_err", err, 1'b0);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_araddr[64*i +: 64] = 64'h2000 + 64'(i) * 64'h100;
    end
    req_arlen = '0;
    @(posedge clk); #1;
    rst         = 1'b1;
    req_arvalid = 4'b1111;
    arready_m   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      aexp = 64'h2000 + 64'(k) * 64'h100;
      gexp = 4'(1) << k;
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_arvalid", arvalid_m, 1'b1);
      chk("t2_arid", arid_m, 16'(k));
      chk("t2_araddr", araddr_m, aexp);
      chk("t2_arlen", arlen_m, 8'd0);
      chk("t2_arready", req_arready, gexp);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t2_gap_arvalid", arvalid_m, 1'b0);
      chk("t2_gap_arready", req_arready, 4'b0000);
    end
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_full_arvalid", arvalid_m, 1'b0);
    end
    chk("t3_outcnt4", dut.out_cnt_q, 8'd4);

    @(posedge clk); #1;
    rvalid_m   = 1'b1;
    rid_m      = 16'd1;
    rlast_m    = 1'b1;
    req_rready = '0;
    @(negedge clk);
    chk("t3_rready_lo", rready_m, 1'b0);
    chk("t3_rvalid1", req_rvalid, 4'b0010);
    @(posedge clk); #1;
    req_rready = 4'b0010;
    @(negedge clk);
    chk("t3_outcnt_hold", dut.out_cnt_q, 8'd4);
    chk("t3_rready_hi", rready_m, 1'b1);
    @(posedge clk); #1;
    rvalid_m   = 1'b0;
    rlast_m    = 1'b0;
    req_rready = '0;
    @(negedge clk);
    chk("t3_outcnt3", dut.out_cnt_q, 8'd3);
    chk("t3_arvalid_lag", arvalid_m, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_regrant", arvalid_m, 1'b1);
    chk("t3_regrant_id", arid_m, 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_outcnt4b", dut.out_cnt_q, 8'd4);
    repeat (2) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("t3_full_again", arvalid_m, 1'b0);
    end

    @(posedge clk); #1;
    arready_m  = 1'b0;
    rvalid_m   = 1'b1;
    rid_m      = 16'd2;
    rlast_m    = 1'b1;
    req_rready = 4'b0100;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_outcnt3", dut.out_cnt_q, 8'd3);
    chk("t4_nogrant", arvalid_m, 1'b0);
    @(posedge clk); #1;
    rvalid_m   = 1'b0;
    rlast_m    = 1'b0;
    req_rready = '0;
    @(negedge clk);
    chk("t4_outcnt2", dut.out_cnt_q, 8'd2);
    chk("t4_arvalid", arvalid_m, 1'b1);
    chk("t4_arid", arid_m, 16'd1);
    @(posedge clk); #1;
    arready_m  = 1'b1;
    rvalid_m   = 1'b1;
    rid_m      = 16'd3;
    rlast_m    = 1'b1;
    req_rready = 4'b1000;
    @(negedge clk);
    chk("t4_arready", req_arready, 4'b0010);
    chk("t4_rvalid", req_rvalid, 4'b1000);
    @(posedge clk); #1;
    arready_m  = 1'b0;
    rvalid_m   = 1'b0;
    rlast_m    = 1'b0;
    req_rready = '0;
    @(negedge clk);
    chk("t4_outcnt_same", dut.out_cnt_q, 8'd2);
    chk("t4_err", err, 1'b0);

    @(posedge clk); #1;
    rvalid_m = 1'b1;
    rid_m    = 16'd5;
    rlast_m  = 1'b0;
    @(negedge clk);
    chk("t5_rready_sink", rready_m, 1'b1);
    chk("t5_rvalid_none", req_rvalid, 4'b0000);
    chk("t5_err_pre", err, 1'b0);
    @(posedge clk); #1;
    rid_m = 16'h0011;
    @(negedge clk);
    chk("t5_err", err, 1'b1);
    chk("t5_upper_rvalid", req_rvalid, 4'b0000);
    chk("t5_upper_rready", rready_m, 1'b1);
    @(posedge clk); #1;
    rvalid_m = 1'b0;
    rid_m    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t5_err_sticky", err, 1'b1);
    chk("t5_issue_id", arid_m, 16'd2);
    chk("t5_outcnt", dut.out_cnt_q, 8'd2);

    @(posedge clk); #1;
    arready_m = 1'b1;
    @(posedge clk); #1;
    arready_m = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_issue", arvalid_m, 1'b1);
    chk("t6_issue_id", arid_m, 16'd3);
    chk("t6_outcnt3", dut.out_cnt_q, 8'd3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_arvalid", arvalid_m, 1'b0);
    chk("t6_outcnt0", dut.out_cnt_q, 8'd0);
    chk("t6_rrptr", dut.rr_ptr_q, 3'd0);
    chk("t6_err", err, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_first_grant", arid_m, 16'd0);
    chk("t6_first_valid", arvalid_m, 1'b1);

    @(posedge clk); #1;
    req_arvalid = '0;
    rvalid_m    = 1'b1;
    rid_m       = 16'd0;
    rlast_m     = 1'b1;
    req_rready  = 4'b0001;
    @(negedge clk);
    chk("t7_rvalid", req_rvalid, 4'b0001);
    chk("t7_err_pre", err, 1'b0);
    @(posedge clk); #1;
    rvalid_m   = 1'b0;
    rlast_m    = 1'b0;
    req_rready = '0;
    @(negedge clk);
    chk("t7_err", err, 1'b1);
    chk("t7_outcnt", dut.out_cnt_q, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
